// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared reset level, funct3 encodings and LSU state type
package common;

    localparam logic RESET = 1'b0;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_funct3_t;

    // Store encodings reuse the load values, so they cannot be separate enum members.
    localparam mem_funct3_t SB = LB;
    localparam mem_funct3_t SH = LH;
    localparam mem_funct3_t SW = LW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction, store merge and access legality for RV32I
module lsu_align
    import common::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word,
    output logic        error
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte  = rdata[{addr_lo, 3'b000} +: 8];
        lane_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_value = rdata;
        case (funct3)
            LB:      load_value = {{24{lane_byte[7]}}, lane_byte};
            LBU:     load_value = {24'd0, lane_byte};
            LH:      load_value = {{16{lane_half[15]}}, lane_half};
            LHU:     load_value = {16'd0, lane_half};
            default: load_value = rdata;
        endcase

        store_word = rdata;
        case (funct3)
            SB:      store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SH: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase

        error = 1'b0;
        if (write) begin
            if (funct3 != SB && funct3 != SH && funct3 != SW) error = 1'b1;
        end else if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
            error = 1'b1;
        end
        if (funct3[1:0] == 2'b01 && addr_lo[0])         error = 1'b1;
        if (funct3[1:0] == 2'b10 && addr_lo != 2'b00)   error = 1'b1;
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for a word-only data memory
module load_store_unit
    import common::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_error,
    output logic                     mem_write_en,
    output logic [ADDRESS_WIDTH+1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    lsu_state_t state, next_state;

    logic                  lat_write;
    logic [2:0]            lat_funct3;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  accept;

    logic [2:0]            al_funct3;
    logic                  al_write;
    logic [1:0]            al_addr_lo;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  al_error;

    assign accept = req_valid && req_ready;

    // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
    assign al_funct3  = (state == IDLE) ? req_funct3    : lat_funct3;
    assign al_write   = (state == IDLE) ? req_write     : lat_write;
    assign al_addr_lo = (state == IDLE) ? req_addr[1:0] : mem_address[1:0];
    assign al_wdata   = (state == IDLE) ? req_wdata     : lat_wdata;

    lsu_align u_align (
        .funct3     (al_funct3),
        .write      (al_write),
        .addr_lo    (al_addr_lo),
        .rdata      (mem_read_data),
        .wdata      (al_wdata),
        .load_value (load_value),
        .store_word (store_word),
        .error      (al_error)
    );

    always_ff @(posedge clk) begin
        if (rst == RESET) state <= IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (al_error)                         next_state = RESP;
                    else if (req_write && req_funct3 == SW) next_state = WRITE;
                    else                                  next_state = READ;
                end
            end
            READ:    next_state = lat_write ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == IDLE) && (rst != RESET);
        resp_valid   = (state == RESP);
        mem_write_en = (state == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            lat_write      <= 1'b0;
            lat_funct3     <= 3'd0;
            lat_wdata      <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write      <= req_write;
                        lat_funct3     <= req_funct3;
                        lat_wdata      <= req_wdata;
                        mem_address    <= req_addr;
                        resp_rdata     <= '0;
                        resp_error     <= al_error;
                        mem_write_data <= (req_write && !al_error && req_funct3 == SW) ? req_wdata : '0;
                    end
                end
                READ: begin
                    if (lat_write) mem_write_data <= store_word;
                    else           resp_rdata     <= load_value;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_en;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    int          write_count = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_write_en && rst) begin
            mem[mem_address[7:2]] <= mem_write_data;
        end
        if (mem_write_en) write_count = write_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic er, output int writes);
        int guard = 0;
        int wc0;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        wc0 = write_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_funct3 = 3'b111; req_addr = 8'hFF; req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_error;
        writes = write_count - wc0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          wr;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 8'd0; req_wdata = 32'd0; pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'd0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            preload(i[5:0], 32'd0);
        end
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", {31'd0, resp_error}, 32'd0);
        check("rst_wen", {31'd0, mem_write_en}, 32'd0);
        check("rst_addr", {24'd0, mem_address}, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);

        preload(6'd2, 32'hDEAD_BEEF);
        preload(6'd1, 32'h1122_3344);
        preload(6'd3, 32'h1122_3344);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        do_req(1'b0, 3'b010, 8'h08, 32'd0, lat, rd, er, wr);
        check("lw_lat", lat, 2);
        check("lw_data", rd, 32'hDEAD_BEEF);
        check("lw_err", {31'd0, er}, 32'd0);
        check("lw_writes", wr, 0);

        do_req(1'b0, 3'b000, 8'h0B, 32'd0, lat, rd, er, wr);
        check("lb_lat", lat, 2);
        check("lb_data", rd, 32'hFFFF_FFDE);
        do_req(1'b0, 3'b100, 8'h0B, 32'd0, lat, rd, er, wr);
        check("lbu_data", rd, 32'h0000_00DE);
        do_req(1'b0, 3'b001, 8'h0A, 32'd0, lat, rd, er, wr);
        check("lh_hi_data", rd, 32'hFFFF_DEAD);
        do_req(1'b0, 3'b101, 8'h08, 32'd0, lat, rd, er, wr);
        check("lhu_lo_data", rd, 32'h0000_BEEF);
        do_req(1'b0, 3'b000, 8'h08, 32'd0, lat, rd, er, wr);
        check("lb_lane0", rd, 32'hFFFF_FFEF);

        do_req(1'b1, 3'b000, 8'h05, 32'hFFFF_FF55, lat, rd, er, wr);
        check("sb_lat", lat, 3);
        check("sb_err", {31'd0, er}, 32'd0);
        check("sb_rdata", rd, 32'd0);
        check("sb_writes", wr, 1);
        check("sb_mem", mem[1], 32'h1122_5544);

        do_req(1'b1, 3'b001, 8'h0E, 32'h1234_ABCD, lat, rd, er, wr);
        check("sh_lat", lat, 3);
        check("sh_writes", wr, 1);
        check("sh_mem", mem[3], 32'hABCD_3344);

        do_req(1'b1, 3'b010, 8'h10, 32'hCAFE_F00D, lat, rd, er, wr);
        check("sw_lat", lat, 2);
        check("sw_writes", wr, 1);
        check("sw_mem", mem[4], 32'hCAFE_F00D);

        do_req(1'b1, 3'b010, 8'h06, 32'h5555_5555, lat, rd, er, wr);
        check("sw_mis_lat", lat, 1);
        check("sw_mis_err", {31'd0, er}, 32'd1);
        check("sw_mis_writes", wr, 0);
        check("sw_mis_mem", mem[1], 32'h1122_5544);
        do_req(1'b0, 3'b001, 8'h03, 32'd0, lat, rd, er, wr);
        check("lh_mis_lat", lat, 1);
        check("lh_mis_err", {31'd0, er}, 32'd1);
        check("lh_mis_rdata", rd, 32'd0);
        do_req(1'b0, 3'b011, 8'h00, 32'd0, lat, rd, er, wr);
        check("f3_011_lat", lat, 1);
        check("f3_011_err", {31'd0, er}, 32'd1);
        do_req(1'b1, 3'b100, 8'h04, 32'h0000_0099, lat, rd, er, wr);
        check("st_f3_100_err", {31'd0, er}, 32'd1);
        check("st_f3_100_writes", wr, 0);

        // Abandon an SB while it is in READ.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 8'h04; req_wdata = 32'h77;
        begin
            int g = 0;
            while (!req_ready && g < 20) begin @(negedge clk); g++; end
        end
        wr = write_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd0);
        check("abort_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_wen", {31'd0, mem_write_en}, 32'd0);
        check("abort_addr", {24'd0, mem_address}, 32'd0);
        check("abort_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_writes", write_count - wr, 0);
        check("abort_mem", mem[1], 32'h1122_5544);
        do_req(1'b0, 3'b010, 8'h04, 32'd0, lat, rd, er, wr);
        check("post_abort_lat", lat, 2);
        check("post_abort_data", rd, 32'h1122_5544);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load or store per handshake from the MEM stage and drives the word-organised data memory's `write_en` / `address` / `write_data` / `read_data` interface. Implements RV32I byte, halfword and word accesses on top of the word-only memory:
- sub-word loads by lane extraction plus sign/zero extension;
- sub-word stores by read-modify-write.

Sits between the pipeline MEM stage and `data_memory`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 6, word-address bits of the attached memory; byte address is `ADDRESS_WIDTH+2` bits.
- `DATA_WIDTH`, 32, data word width; fixed at 32 for RV32I lane logic.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-low reset; compared against `common::RESET` (1'b0).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`  in  `ADDRESS_WIDTH+2`  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_error`  out  1  misaligned address or illegal funct3; valid with `resp_valid`.
- `mem_write_en`  out  1  to memory `write_en`.
- `mem_address`  out  `ADDRESS_WIDTH+2`  to memory `address` (byte address; memory drops bits [1:0]).
- `mem_write_data`  out  32  to memory `write_data`.
- `mem_read_data`  in  32  from memory `read_data` (combinational read).

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- `req_ready` = 1 only in IDLE. A request is accepted on `req_valid && req_ready`; `req_write`, `req_funct3`, `req_addr` and `req_wdata` are latched.
- Error check at accept:
  - H/HU with `addr[0]=1` is an error.
  - W with `addr[1:0]!=0` is an error.
  - funct3 011, 110 or 111 is an error; for stores, any funct3 other than 000/001/010 is an error.
  - Error → RESP with `resp_error=1`. No memory write is issued.
- Transitions from IDLE on accept:
  - Load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- READ:
  - `mem_address` = latched address.
  - For loads, the extracted value is registered into `resp_rdata`, then → RESP.
  - For stores, `mem_read_data` is merged with the store data into the write register, then → WRITE.
- WRITE: `mem_write_en=1` for exactly this cycle, with merged/full word on `mem_write_data`, then → RESP.
- RESP: `resp_valid=1` for one cycle, then → IDLE. No response backpressure.
- Load extraction:
  - B/BU: byte lane `addr[1:0]`, sign/zero-extended.
  - H/HU: half lane `addr[1]`, sign/zero-extended.
  - W: full word.
- Store merge:
  - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half lane `addr[1]` with `wdata[15:0]`.
  - All other bits keep the read value.
- `mem_write_en` is asserted in no state other than WRITE.

## Timing
- Accept in cycle 0 (IDLE). `resp_valid` arrives at:
  - Load: cycle 2.
  - SW: cycle 2.
  - SB/SH: cycle 3.
  - Error: cycle 1.
- Back-to-back: the next request can be accepted in the cycle after RESP.
- `mem_address` holds the latched address from the cycle after accept through RESP. It is only required to be meaningful in READ and WRITE.
- Reset (`rst==RESET` at a clock edge) sets:
  - state to IDLE;
  - `resp_valid`, `resp_rdata`, `resp_error`, `mem_write_en`, `mem_address`, `mem_write_data` to 0.
- While `rst` is asserted, `req_ready=0`. It is 1 in the first cycle after reset deasserts.
- Reset mid-operation abandons the request with no response.
  - Reset during READ of an SB/SH: no write occurs.
  - Reset in the same cycle as WRITE still takes precedence at the memory, because memory reset clears all words.
- `req_*` changes while not in IDLE are ignored.

## Structure
- `common` package holds:
  - `RESET`;
  - `typedef enum logic [2:0] mem_funct3_t` (LB, LH, LW, LBU, LHU; SB, SH, SW);
  - `typedef enum logic [1:0] lsu_state_t`.
- One combinational sub-module, `lsu_align`: inputs funct3, `addr[1:0]`, read word and store data; outputs extended load value, merged store word and error. `load_store_unit` holds the FSM and registers.

## Test plan
- LW at 0x08 with memory word 2 = 0xDEADBEEF → `resp_valid` at cycle 2, `resp_rdata=0xDEADBEEF`, `resp_error=0`.
- LB and LBU at 0x0B on word 0xDEADBEEF:
  - LB → 0xFFFFFFDE.
  - LBU → 0x000000DE.
- SB 0x55 at 0x05 over word 1 = 0x11223344:
  - READ then WRITE; one-cycle `mem_write_en`.
  - Word 1 becomes 0x11225544.
  - `resp_valid` at cycle 3.
- SH 0xABCD at 0x0E over word 3 = 0x11223344 → word 3 becomes 0xABCD3344.
- Error cases, each with `resp_error=1`, `resp_valid` at cycle 1 and `mem_write_en` never asserted:
  - SW at 0x06.
  - LH at 0x03.
  - funct3=011.
- Reset asserted during READ of SB → no write, state IDLE, all outputs 0. Next accepted LW returns correct data.
